// File: rtl/mult8_shift_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mult8_shift_add_ctrl_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - ALU_WIDTH : datapath width of the shared ripple-carry adder
//   - state_e   : controller state encoding (IDLE / RUN / DONE)
//   - gate_operand() : Q[0]-gated multiplicand select feeding the adder
// ---------------------------------------------------------------------------
package mult8_shift_add_ctrl_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Partial-product select: the multiplicand is added only when the
    // current low multiplier bit is set, otherwise zero is added.
    function automatic logic [ALU_WIDTH-1:0] gate_operand(
        input logic                 sel,
        input logic [ALU_WIDTH-1:0] operand
    );
        logic [ALU_WIDTH-1:0] result;
        if (sel) begin
            result = operand;
        end else begin
            result = {ALU_WIDTH{1'b0}};
        end
        return result;
    endfunction

endpackage

// File: rtl/mult8_shift_add_ctrl_rca.sv
// ---------------------------------------------------------------------------
// rca_8bit
// Plain 8-bit ripple-carry adder built from a chain of full adders.
// Ports:
//   i_a, i_b  [7:0]  addends
//   i_cin            carry in
//   o_sum     [7:0]  sum
//   o_cout           carry out of bit 7
// ---------------------------------------------------------------------------
module rca_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [8:0] w_carry;

    assign w_carry[0] = i_cin;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_fa
            assign o_sum[g]     = i_a[g] ^ i_b[g] ^ w_carry[g];
            assign w_carry[g+1] = (i_a[g] & i_b[g]) |
                                  (i_a[g] & w_carry[g]) |
                                  (i_b[g] & w_carry[g]);
        end
    endgenerate

    assign o_cout = w_carry[8];

endmodule

// File: rtl/mult8_shift_add_ctrl.sv
// ---------------------------------------------------------------------------
// mult8_shift_add_ctrl
// Sequential 8x8 unsigned shift-and-add multiplier. One shared 8-bit
// ripple-carry adder is reused over 8 iterations to build a 16-bit product.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         operation request, sampled only in IDLE
//   abort         cancel, effective only in RUN (also masks start in IDLE)
//   multiplicand  operand M, captured on accepted start
//   multiplier    operand Q, captured on accepted start
//   busy          high in RUN and DONE
//   done          one-cycle pulse, product valid
//   product       {A,Q}; holds the last result until the next accepted start
// WIDTH must stay 8: the shared adder is a fixed 8-bit block.
// ---------------------------------------------------------------------------
module mult8_shift_add_ctrl
    import mult8_shift_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             r_state;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_q;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    // Adder operand: multiplicand gated by the current low multiplier bit.
    assign w_add_b = gate_operand(r_q[0], r_m);

    rca_8bit u_adder (
        .i_a    (r_a),
        .i_b    (w_add_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Controller FSM plus datapath registers; busy/done are registered
    // alongside the state so they change on the same edge as it.
    // The adder carry is shifted straight into A[7], so no separate carry
    // register is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_m     <= {WIDTH{1'b0}};
            r_a     <= {WIDTH{1'b0}};
            r_q     <= {WIDTH{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    // abort masks a simultaneous start
                    if (start && !abort) begin
                        r_m     <= multiplicand;
                        r_q     <= multiplier;
                        r_a     <= {WIDTH{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_a     <= {WIDTH{1'b0}};
                        r_q     <= {WIDTH{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        // 17-bit {C,S,Q} shifted right by one
                        r_a   <= {w_cout, w_sum[WIDTH-1:1]};
                        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (r_cnt == LAST_ITER) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_done  <= 1'b0;
                            r_state <= ST_RUN;
                        end
                        r_busy <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_a     <= {WIDTH{1'b0}};
                    r_q     <= {WIDTH{1'b0}};
                    r_cnt   <= {CNT_W{1'b0}};
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = {r_a, r_q};

endmodule
